// File: rtl/ar_disp_if.sv
// Signal bundle between the ARINC display page sequencer and its environment.
// The master side drives the controls, and the sequencer drives the page outputs.
interface ar_disp_if;
  logic       btn_next;
  logic       auto_en;
  logic       snap_en;
  logic       rx_stb;
  logic [1:0] S;
  logic       page_stb;
  logic       new_rx;

  modport master (
    output btn_next, auto_en, snap_en, rx_stb,
    input  S, page_stb, new_rx
  );

  modport slave (
    input  btn_next, auto_en, snap_en, rx_stb,
    output S, page_stb, new_rx
  );
endinterface

// File: rtl/ar_disp_seq.sv
// Page sequencer for the 4-page ARINC TX/RX display mux.
// Pages advance on a dwell timer, on a debounced button, or snap to page 0 on a new RX word.
module ar_disp_seq #(
  parameter int unsigned DWELL_CYC = 50_000_000,
  parameter int unsigned DEB_CYC   = 1_000_000
) (
  input logic      clk,
  input logic      rst,
  ar_disp_if.slave bus
);

  localparam int unsigned DwellW = $clog2(DWELL_CYC);
  localparam int unsigned DebW   = $clog2(DEB_CYC);

  logic [1:0]        sync_q;
  logic              btn_d_q, btn_d_d;
  logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [DwellW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]        s_q, s_d;
  logic              page_stb_q, page_stb_d;
  logic              new_rx_q, new_rx_d;

  logic btn_s, deb_fire, press, tick, snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      btn_d_q     <= 1'b0;
      deb_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      s_q         <= '0;
      page_stb_q  <= 1'b0;
      new_rx_q    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.btn_next};
      btn_d_q     <= btn_d_d;
      deb_cnt_q   <= deb_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      s_q         <= s_d;
      page_stb_q  <= page_stb_d;
      new_rx_q    <= new_rx_d;
    end
  end

  always_comb begin
    btn_s    = sync_q[1];
    deb_fire = (btn_s != btn_d_q) && (deb_cnt_q == DebW'(DEB_CYC - 1));
    // Only an accepted rising level is an event; release is silent.
    press    = deb_fire && btn_s;
    tick     = bus.auto_en && (dwell_cnt_q == DwellW'(DWELL_CYC - 1));
    snap     = bus.rx_stb && bus.snap_en;

    btn_d_d   = deb_fire ? btn_s : btn_d_q;
    deb_cnt_d = ((btn_s == btn_d_q) || deb_fire) ? '0 : deb_cnt_q + 1'b1;

    s_d         = s_q;
    dwell_cnt_d = bus.auto_en ? dwell_cnt_q + 1'b1 : '0;
    if (snap) begin
      s_d         = '0;
      dwell_cnt_d = '0;
    end else if (press) begin
      s_d         = s_q + 2'd1;
      dwell_cnt_d = '0;
    end else if (tick) begin
      s_d         = s_q + 2'd1;
      dwell_cnt_d = '0;
    end

    page_stb_d = (s_d != s_q);

    // A new word beats a simultaneous press, so the flag is never lost.
    if (bus.rx_stb) begin
      new_rx_d = 1'b1;
    end else if (press) begin
      new_rx_d = 1'b0;
    end else begin
      new_rx_d = new_rx_q;
    end
  end

  assign bus.S        = s_q;
  assign bus.page_stb = page_stb_q;
  assign bus.new_rx   = new_rx_q;

endmodule

// File: tb/tb_ar_disp_seq.sv
// Directed bench for ar_disp_seq with short dwell and debounce periods.
module tb_ar_disp_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   stb_cnt  = 0;

  ar_disp_if bus ();

  ar_disp_seq #(
    .DWELL_CYC (8),
    .DEB_CYC   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.page_stb === 1'b1) stb_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  // Hold long enough to be accepted, then release long enough to settle.
  task automatic press_btn();
    bus.btn_next = 1'b1;
    cyc(10);
    bus.btn_next = 1'b0;
    cyc(10);
  endtask

  initial begin
    bus.btn_next = 1'b0;
    bus.auto_en  = 1'b0;
    bus.snap_en  = 1'b0;
    bus.rx_stb   = 1'b0;
    cyc(1);
    do_reset();
    check("rst_S", 32'(bus.S), 0);
    check("rst_page_stb", 32'(bus.page_stb), 0);
    check("rst_new_rx", 32'(bus.new_rx), 0);

    // 1: auto advance every 8 cycles
    stb_cnt     = 0;
    bus.auto_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc(7);
      check("auto_hold", 32'(bus.S), 32'((k - 1) % 4));
      cyc(1);
      check("auto_step", 32'(bus.S), 32'(k % 4));
    end
    cyc(1);
    check("auto_stb_count", 32'(stb_cnt), 5);

    // 2: manual presses, glitch, snap disabled, wrap
    bus.auto_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      press_btn();
      check("manual_step", 32'(bus.S), 32'(k));
    end
    bus.btn_next = 1'b1;
    cyc(2);
    bus.btn_next = 1'b0;
    cyc(10);
    check("glitch_ignored", 32'(bus.S), 3);
    bus.rx_stb = 1'b1;
    cyc(1);
    bus.rx_stb = 1'b0;
    check("nosnap_S", 32'(bus.S), 3);
    check("nosnap_new_rx", 32'(bus.new_rx), 1);
    press_btn();
    check("wrap_S", 32'(bus.S), 0);
    check("press_clears_new_rx", 32'(bus.new_rx), 0);

    // 3: snap from page 2 in auto mode restarts dwell
    do_reset();
    press_btn();
    press_btn();
    check("pre_snap_S", 32'(bus.S), 2);
    bus.auto_en = 1'b1;
    bus.snap_en = 1'b1;
    bus.rx_stb  = 1'b1;
    cyc(1);
    bus.rx_stb = 1'b0;
    check("snap_S", 32'(bus.S), 0);
    check("snap_new_rx", 32'(bus.new_rx), 1);
    check("snap_page_stb", 32'(bus.page_stb), 1);
    cyc(7);
    check("snap_dwell_hold", 32'(bus.S), 0);
    cyc(1);
    check("snap_dwell_tick", 32'(bus.S), 1);
    cyc(8);
    check("tick_to_2", 32'(bus.S), 2);
    bus.snap_en = 1'b0;
    bus.rx_stb  = 1'b1;
    cyc(1);
    bus.rx_stb  = 1'b0;
    bus.auto_en = 1'b0;
    check("nosnap_auto_S", 32'(bus.S), 2);
    check("nosnap_auto_new_rx", 32'(bus.new_rx), 1);

    // 4: rx_stb and press on the same edge, snap enabled, already on page 0
    do_reset();
    bus.snap_en  = 1'b1;
    bus.btn_next = 1'b1;
    cyc(5);
    bus.rx_stb = 1'b1;
    cyc(1);
    bus.rx_stb = 1'b0;
    check("tie_S", 32'(bus.S), 0);
    check("tie_new_rx", 32'(bus.new_rx), 1);
    check("tie_no_stb", 32'(bus.page_stb), 0);
    bus.btn_next = 1'b0;
    cyc(12);
    check("tie_settle_S", 32'(bus.S), 0);
    check("tie_settle_new_rx", 32'(bus.new_rx), 1);

    // 5: press at dwell_cnt=5 restarts dwell; auto_en low freezes S
    bus.snap_en = 1'b0;
    do_reset();
    bus.auto_en  = 1'b1;
    bus.btn_next = 1'b1;
    cyc(6);
    check("mid_dwell_press", 32'(bus.S), 1);
    cyc(7);
    check("dwell_restart_hold", 32'(bus.S), 1);
    cyc(1);
    check("dwell_restart_tick", 32'(bus.S), 2);
    bus.auto_en = 1'b0;
    cyc(20);
    check("auto_off_frozen", 32'(bus.S), 2);
    bus.auto_en = 1'b1;
    cyc(7);
    check("auto_on_hold", 32'(bus.S), 2);
    cyc(1);
    check("auto_on_tick", 32'(bus.S), 3);
    bus.auto_en  = 1'b0;
    bus.btn_next = 1'b0;

    // 6: async reset mid-debounce discards the press
    do_reset();
    press_btn();
    press_btn();
    press_btn();
    bus.rx_stb = 1'b1;
    cyc(1);
    bus.rx_stb = 1'b0;
    check("pre_rst_S", 32'(bus.S), 3);
    check("pre_rst_new_rx", 32'(bus.new_rx), 1);
    bus.btn_next = 1'b1;
    cyc(4);
    rst = 1'b1;
    #1;
    check("async_rst_S", 32'(bus.S), 0);
    check("async_rst_new_rx", 32'(bus.new_rx), 0);
    bus.btn_next = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(12);
    check("no_press_after_rst", 32'(bus.S), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
